// File: rtl/fcb_pkg.sv
// rtl/fcb_pkg.sv - shared types and constants for the ping-pong frame capture buffer
package fcb_pkg;

  localparam int IMG_WIDTH_DEF  = 160;
  localparam int IMG_HEIGHT_DEF = 120;

  // RGB565 field positions: [15:11]=R, [10:5]=G, [4:0]=B
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;
  localparam int PIX_WIDTH = R_MSB - B_LSB + 1;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } cap_state_t;

endpackage

// File: rtl/simple_dp_ram.sv
// rtl/simple_dp_ram.sv - one write port, one registered read port, no reset (BRAM style)
module simple_dp_ram #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_capture_buffer.sv
// rtl/frame_capture_buffer.sv - double-buffered RGB565 frame store with tear-free bank swap
module frame_capture_buffer
  import fcb_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic                  wr_sof,
  input  logic [PIX_WIDTH-1:0]  wr_data,
  input  logic                  freeze,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [PIX_WIDTH-1:0]  frame_buffer_data,
  output logic                  frame_valid,
  output logic                  frame_done,
  output logic                  short_frame_err,
  output logic                  capturing
);

  localparam int PIX_COUNT = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW        = ADDR_WIDTH;
  localparam logic [AW:0]   PIX_CNT_W = (AW + 1)'(PIX_COUNT);
  localparam logic [AW-1:0] LAST_ADDR = AW'(PIX_COUNT - 1);

  cap_state_t     state, next_state;
  logic [AW-1:0]  wr_cnt, cnt_nxt;
  logic [AW-1:0]  wr_addr;
  logic           wr_en;
  logic           do_swap, do_err;
  logic           front_bank;
  logic           rd_oor, mask_q;
  logic [AW:0]    rd_phys, wr_phys;
  logic [PIX_WIDTH-1:0] ram_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      wr_cnt          <= '0;
      front_bank      <= 1'b0;
      frame_valid     <= 1'b0;
      frame_done      <= 1'b0;
      short_frame_err <= 1'b0;
      mask_q          <= 1'b1;
    end else begin
      state           <= next_state;
      wr_cnt          <= cnt_nxt;
      if (do_swap) begin
        front_bank <= ~front_bank;
      end
      frame_valid     <= frame_valid | do_swap;
      frame_done      <= do_swap;
      short_frame_err <= do_err;
      mask_q          <= ~frame_valid | rd_oor;
    end
  end

  // frame_done high means the swap cycle: a pixel there is upstream misbehaviour and is dropped
  always_comb begin
    next_state = state;
    cnt_nxt    = wr_cnt;
    wr_en      = 1'b0;
    wr_addr    = wr_cnt;
    do_swap    = 1'b0;
    do_err     = 1'b0;
    case (state)
      IDLE: begin
        if (wr_valid && wr_sof && !freeze && !frame_done) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          cnt_nxt    = AW'(1);
          next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        if (wr_valid) begin
          if (wr_sof) begin
            do_err = 1'b1;
            if (freeze) begin
              cnt_nxt    = '0;
              next_state = IDLE;
            end else begin
              wr_en   = 1'b1;
              wr_addr = '0;
              cnt_nxt = AW'(1);
            end
          end else begin
            wr_en = 1'b1;
            if (wr_cnt == LAST_ADDR) begin
              do_swap    = 1'b1;
              cnt_nxt    = '0;
              next_state = IDLE;
            end else begin
              cnt_nxt = wr_cnt + AW'(1);
            end
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign capturing = (state == CAPTURE);

  // Bank b occupies words [b*PIX_COUNT, (b+1)*PIX_COUNT); out-of-range reads are clamped and masked
  assign rd_oor  = ({1'b0, read_addr} >= PIX_CNT_W);
  assign rd_phys = rd_oor ? '0 : ({1'b0, read_addr} + (front_bank ? PIX_CNT_W : '0));
  assign wr_phys = {1'b0, wr_addr} + (front_bank ? '0 : PIX_CNT_W);

  simple_dp_ram #(
    .DEPTH (2 * PIX_COUNT),
    .WIDTH (PIX_WIDTH),
    .AW    (AW + 1)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_phys),
    .wr_data (wr_data),
    .rd_addr (rd_phys),
    .rd_data (ram_q)
  );

  assign frame_buffer_data = mask_q ? '0 : ram_q;

endmodule
